// File: rtl/iomem_timer.sv
// Memory-mapped 32-bit timer responding on the SoC iomem bus: CTRL/COUNT/COMPARE/STATUS
// registers, one-wait-state ready handshake and a registered level interrupt.
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  // Handshake: a request is accepted when iomem_valid && sel && !iomem_ready.
  // iomem_ready pulses for exactly one cycle after the accepting edge; the
  // !iomem_ready guard stops a second accept while the initiator still holds
  // valid during that ready cycle. rdata is nonzero only while ready is high.

  localparam logic [31:0] CTRL_MASK = 32'hFFFF_0007;

  logic [31:0] ctrl_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [1:0]  status_q;
  logic [15:0] pre_cnt_q;

  logic        sel;
  logic        accept;
  logic        is_write;
  logic [5:0]  word;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic [31:0] wmask;

  logic        en;
  logic        autoreload;
  logic        irqen;
  logic [15:0] prescale;
  logic        tick;
  logic        cmp_hit;
  logic        match_set;
  logic        ovf_set;

  logic [31:0] count_tick;
  logic [31:0] count_next;
  logic [31:0] compare_next;
  logic [31:0] ctrl_next;
  logic [1:0]  status_clr;
  logic [1:0]  status_next;
  logic [15:0] pre_cnt_next;
  logic [31:0] rd_mux;

  logic        unused_addr_lsbs;

  assign sel      = (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign accept   = iomem_valid && sel && !iomem_ready;
  assign is_write = |iomem_wstrb;
  assign word     = iomem_addr[7:2];

  assign wr_ctrl    = accept && is_write && (word == 6'd0);
  assign wr_count   = accept && is_write && (word == 6'd1);
  assign wr_compare = accept && is_write && (word == 6'd2);
  assign wr_status  = accept && is_write && (word == 6'd3);

  assign wmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                  {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

  assign unused_addr_lsbs = ^iomem_addr[1:0];

  assign en         = ctrl_q[0];
  assign autoreload = ctrl_q[1];
  assign irqen      = ctrl_q[2];
  assign prescale   = ctrl_q[31:16];

  assign tick    = en && (pre_cnt_q == prescale);
  assign cmp_hit = (count_q == compare_q);

  // Tick update of COUNT; the overflow flag only fires on a real increment.
  always_comb begin
    count_tick = count_q;
    match_set  = 1'b0;
    ovf_set    = 1'b0;
    if (tick) begin
      match_set = cmp_hit;
      if (cmp_hit && autoreload) begin
        count_tick = 32'h0;
      end else begin
        count_tick = count_q + 32'd1;
        ovf_set    = &count_q;
      end
    end
  end

  // Bus writes overlay the tick-updated value byte by byte.
  always_comb begin
    count_next   = count_tick;
    compare_next = compare_q;
    ctrl_next    = ctrl_q;
    status_clr   = 2'b00;
    if (wr_count) begin
      count_next = (iomem_wdata & wmask) | (count_tick & ~wmask);
    end
    if (wr_compare) begin
      compare_next = (iomem_wdata & wmask) | (compare_q & ~wmask);
    end
    if (wr_ctrl) begin
      ctrl_next = ((iomem_wdata & wmask) | (ctrl_q & ~wmask)) & CTRL_MASK;
    end
    if (wr_status && iomem_wstrb[0]) begin
      status_clr = iomem_wdata[1:0];
    end
    // A new event on the clearing edge keeps its flag set.
    status_next = (status_q & ~status_clr) | {ovf_set, match_set};
  end

  always_comb begin
    pre_cnt_next = pre_cnt_q + 16'd1;
    if (wr_ctrl || !en || tick) begin
      pre_cnt_next = 16'h0;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (word)
      6'd0:    rd_mux = ctrl_q;
      6'd1:    rd_mux = count_q;
      6'd2:    rd_mux = compare_q;
      6'd3:    rd_mux = {30'h0, status_q};
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q      <= 32'h0;
      count_q     <= 32'h0;
      compare_q   <= 32'h0;
      status_q    <= 2'b00;
      pre_cnt_q   <= 16'h0;
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0;
      irq         <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_next;
      count_q     <= count_next;
      compare_q   <= compare_next;
      status_q    <= status_next;
      pre_cnt_q   <= pre_cnt_next;
      iomem_ready <= accept;
      iomem_rdata <= accept ? rd_mux : 32'h0;
      irq         <= irqen && (|status_q);
    end
  end

endmodule

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped 32-bit timer that answers the SoC's external `iomem_*` bus. The CPU core is the initiator; this block is the responder. It decodes a 256-byte window and serves control, count, compare and status registers with a one-wait-state ready handshake. Its level interrupt is wired to one bit of the SoC's `ex_irq` input, which maps to CPU `irq[31:8]`.

## Interface
Parameters:
- `BASE_ADDR`, default `32'h0300_0000`: window base. The block is selected when `iomem_addr[31:8] == BASE_ADDR[31:8]`.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low. Clock is `clk`.
- `iomem_valid` in 1: initiator request. It is held high until ready is seen.
- `iomem_ready` out 1: one-cycle acknowledge.
- `iomem_wstrb` in 4: byte write strobes. All zero means a read.
- `iomem_addr` in 32: byte address. Only word-aligned accesses are used; `addr[1:0]` is ignored.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data. It is valid only while `iomem_ready` is high and is 0 otherwise.
- `irq` out 1: level interrupt.

## Operation
Register map (offset = `iomem_addr[7:0]`):
- `0x00` CTRL, r/w:
  - bit0 EN
  - bit1 AUTORELOAD
  - bit2 IRQEN
  - bits[31:16] PRESCALE
  - other bits read 0
- `0x04` COUNT, r/w: 32-bit counter.
- `0x08` COMPARE, r/w: 32-bit.
- `0x0C` STATUS:
  - bit0 MATCH, bit1 OVF
  - write-1-to-clear per bit
  - other bits read 0
- Any other offset inside the window reads 0, ignores writes, and is still acknowledged.
- Addresses outside the window are never acknowledged: `iomem_ready` stays 0 and `iomem_rdata` stays 0. This lets the SoC OR several responders.

Bus handshake:
- Accept when `iomem_valid && sel && !iomem_ready`.
- On the accepting edge:
  - register `iomem_ready=1`
  - latch read data
  - apply writes with byte-strobe granularity
- `iomem_ready` is cleared on the following edge unconditionally. The `!iomem_ready` guard prevents a double acknowledge while the initiator still holds `valid` during the ready cycle.

Prescaler and counter:
- 16-bit `pre_cnt`.
  - When EN=0: `pre_cnt` is held at 0.
  - When EN=1: it increments each cycle. At `pre_cnt==PRESCALE` it returns to 0 and produces a one-cycle `tick`.
  - Any CTRL write (any strobe) clears `pre_cnt`.
- On `tick`:
  - If `COUNT==COMPARE`: set MATCH. COUNT becomes 0 if AUTORELOAD=1, else COUNT+1.
  - Else: COUNT becomes COUNT+1.
  - If COUNT was `0xFFFFFFFF` and increments: it wraps to 0 and sets OVF. MATCH is also set if COMPARE is `0xFFFFFFFF`.
- Auto-reload period is (PRESCALE+1)·(COMPARE+1) cycles.
- `irq = IRQEN & (MATCH | OVF)`. It is registered.

Simultaneous events:
- A bus write to COUNT on the same edge as a `tick` takes the written bytes. Unwritten bytes take the tick-updated value.
- A STATUS W1C on the same edge as a new set event leaves the flag set (set wins).
- A CTRL write clearing EN on a tick edge: the tick still takes effect, and counting stops afterwards.

## Timing
- Reset values, all 0: CTRL, COUNT, COMPARE, STATUS, `pre_cnt`, `iomem_ready`, `iomem_rdata`, `irq`.
- Reset mid-transaction: `iomem_ready` is 0 on the cycle after the reset edge. The initiator is also in reset, so no acknowledge is owed.
- Access latency: `valid` first high in cycle N gives `iomem_ready=1` in cycle N+1 only.
- Minimum access spacing is 2 cycles. A new request accepted in N+2 acknowledges in N+3.
- A written register reads back its new value in any access accepted at N+1 or later.
- Event-to-`irq` latency:
  - A flag sets on the tick edge E.
  - `irq` rises at edge E+1.
  - The SoC adds 1 more register stage before the CPU.
- After a W1C clear at edge W, `irq` falls at W+1, provided no new event occurs.
- A read of COUNT returns the value before the accepting edge's update.

## Test plan
- Reset, then read CTRL/COUNT/COMPARE/STATUS at `0x0300_0000..0C`:
  - all read 0
  - `iomem_ready` is exactly 1 cycle wide, one cycle after `valid`
  - `irq=0`
- Access `0x0400_0000`, held 5 cycles: `iomem_ready` and `iomem_rdata` stay 0 throughout.
- Byte write to COMPARE with wstrb=`4'b0010`, data `0xAABBCCDD`, onto a previous `0x11223344`: reads back `0x1122CC44`. Offset `0x40` reads 0.
- PRESCALE=3, COMPARE=4, AUTORELOAD=1, IRQEN=1, EN=1:
  - first MATCH after 20 cycles
  - `irq` rises one cycle later
  - COUNT sequence is 0..4,0
  - writing STATUS=1 drops `irq` the next cycle
  - the next MATCH follows 20 cycles after the previous one
- COUNT=`0xFFFFFFFE`, PRESCALE=0, AUTORELOAD=0, COMPARE=0: after 2 ticks COUNT=0, OVF=1, MATCH=0.
- Collision cases:
  - W1C of MATCH on the same edge as a new match leaves MATCH=1.
  - A COUNT write of `0x100` coincident with a tick reads back `0x100`.
